// File: rtl/find_max_arbiter.sv
// find_max_arbiter: round-robins whole jobs from two
// operand streams onto one shared find_MAX instance.
module find_max_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_valid,
  output logic          c0_ready,
  input  logic [DW-1:0] c0_a,
  input  logic [DW-1:0] c0_b,
  input  logic [2:0]    c0_instr,
  input  logic          c0_last,
  input  logic          c1_valid,
  output logic          c1_ready,
  input  logic [DW-1:0] c1_a,
  input  logic [DW-1:0] c1_b,
  input  logic [2:0]    c1_instr,
  input  logic          c1_last,
  output logic          fm_start,
  output logic          fm_valid,
  output logic          fm_one_left,
  output logic [2:0]    fm_instruction,
  output logic [DW-1:0] fm_data_a,
  output logic [DW-1:0] fm_data_b,
  input  logic [DW-1:0] fm_maximum,
  input  logic          fm_finish,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_max,
  output logic          res_id
);

  typedef enum logic [2:0] {
    IDLE, START, FILL, STREAM,
    ONE_LEFT, LAST, WAIT, RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          gid;
  logic          rr;
  logic          grant;
  logic          any_req;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_a;
  logic [DW-1:0] g_b;
  logic [2:0]    g_instr;
  logic          c_rdy;
  logic          acc;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;
  logic [2:0]    instr_q;
  logic [DW-1:0] max_q;

  // Granted-client view of the two request streams.
  always_comb begin
    g_valid = gid ? c1_valid : c0_valid;
    g_last  = gid ? c1_last  : c0_last;
    g_a     = gid ? c1_a     : c0_a;
    g_b     = gid ? c1_b     : c0_b;
    g_instr = gid ? c1_instr : c0_instr;
    any_req = c0_valid | c1_valid;
    grant   = (c0_valid & c1_valid) ? ~rr : c1_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and find_MAX protocol strobes.
  always_comb begin
    state_nx    = state;
    fm_start    = 1'b0;
    fm_valid    = 1'b0;
    fm_one_left = 1'b0;
    c_rdy       = 1'b0;
    res_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = START;
      end
      START: begin
        fm_start = 1'b1;
        state_nx = FILL;
      end
      FILL: begin
        c_rdy = 1'b1;
        if (g_valid)
          state_nx = g_last ? ONE_LEFT : STREAM;
      end
      STREAM: begin
        c_rdy = 1'b1;
        if (g_valid) begin
          fm_valid = 1'b1;
          if (g_last) begin
            fm_one_left = 1'b1;
            state_nx    = LAST;
          end
        end
      end
      ONE_LEFT: begin
        fm_one_left = 1'b1;
        state_nx    = LAST;
      end
      LAST: begin
        fm_valid = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (fm_finish) state_nx = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    acc      = c_rdy & g_valid;
    c0_ready = c_rdy & ~gid;
    c1_ready = c_rdy & gid;
  end

  // Grant id and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gid <= 1'b0;
      rr  <= 1'b1;
    end else begin
      if (state == IDLE && any_req) gid <= grant;
      if (state == RESP && res_ready) rr <= gid;
    end
  end

  // One-beat hold register gives one_left its look-ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a  <= '0;
      hold_b  <= '0;
      instr_q <= '0;
    end else if (acc) begin
      hold_a <= g_a;
      hold_b <= g_b;
      if (state == FILL) instr_q <= g_instr;
    end
  end

  // Capture the job maximum when find_MAX finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      max_q <= '0;
    else if (state == WAIT && fm_finish)
      max_q <= fm_maximum;
  end

  assign fm_instruction = instr_q;
  assign fm_data_a      = hold_a;
  assign fm_data_b      = hold_b;
  assign res_max        = max_q;
  assign res_id         = gid;

endmodule

// File: tb/tb_find_max_arbiter.sv
// tb_find_max_arbiter: directed and random jobs against
// a behavioural find_MAX and a job-level reference.
module tb_find_max_arbiter;

  logic       clk;
  logic       rst_n;
  logic       c0_valid, c0_ready, c0_last;
  logic [7:0] c0_a, c0_b;
  logic [2:0] c0_instr;
  logic       c1_valid, c1_ready, c1_last;
  logic [7:0] c1_a, c1_b;
  logic [2:0] c1_instr;
  logic       fm_start, fm_valid, fm_one_left;
  logic [2:0] fm_instruction;
  logic [7:0] fm_data_a, fm_data_b;
  logic [7:0] fm_maximum;
  logic       fm_finish;
  logic       res_valid, res_ready;
  logic [7:0] res_max;
  logic       res_id;

  find_max_arbiter #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_valid(c0_valid), .c0_ready(c0_ready),
    .c0_a(c0_a), .c0_b(c0_b),
    .c0_instr(c0_instr), .c0_last(c0_last),
    .c1_valid(c1_valid), .c1_ready(c1_ready),
    .c1_a(c1_a), .c1_b(c1_b),
    .c1_instr(c1_instr), .c1_last(c1_last),
    .fm_start(fm_start), .fm_valid(fm_valid),
    .fm_one_left(fm_one_left),
    .fm_instruction(fm_instruction),
    .fm_data_a(fm_data_a), .fm_data_b(fm_data_b),
    .fm_maximum(fm_maximum), .fm_finish(fm_finish),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_max(res_max), .res_id(res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  logic [7:0] ja [2][8];
  logic [7:0] jb [2][8];
  logic [2:0] jins [2];
  int         jn [2];

  function automatic logic [7:0] op(
    input logic [2:0] i,
    input logic [7:0] a,
    input logic [7:0] b);
    case (i)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] mx(
    input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [7:0] ref_max(input int id);
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < jn[id]; i++)
      m = mx(m, op(jins[id], ja[id][i], jb[id][i]));
    return m;
  endfunction

  // Behavioural find_MAX: finishes one cycle after the
  // valid beat that follows one_left.
  logic [7:0] fa;
  logic       fol;
  int         vcnt, ol_at;
  logic       ol_nov;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_finish  <= 1'b0;
      fm_maximum <= 8'd0;
      fa <= 8'd0; fol <= 1'b0;
      vcnt <= 0; ol_at <= 0; ol_nov <= 1'b0;
    end else begin
      fm_finish <= 1'b0;
      if (fm_start) begin
        fa <= 8'd0; fol <= 1'b0;
        vcnt <= 0; ol_at <= 0; ol_nov <= 1'b0;
      end else begin
        if (fm_one_left) begin
          fol <= 1'b1;
          if (fm_valid) ol_at <= vcnt + 1;
          else ol_nov <= 1'b1;
        end
        if (fm_valid) begin
          vcnt <= vcnt + 1;
          fa <= mx(fa, op(fm_instruction,
                          fm_data_a, fm_data_b));
          if (fol) begin
            fm_finish  <= 1'b1;
            fm_maximum <= mx(fa, op(fm_instruction,
                                    fm_data_a, fm_data_b));
          end
        end
      end
    end
  end

  // Result monitor: handshakes and res_valid rises.
  logic [7:0] mq [$];
  logic       iq [$];
  int         rq [$];
  logic       rv_d = 1'b0;
  logic       watch = 1'b0;
  logic       c1_early = 1'b0;
  int         hs_cnt = 0;
  int         watch_base = 0;
  always @(posedge clk) begin
    rv_d <= res_valid;
    if (res_valid && !rv_d) rq.push_back(cyc);
    if (res_valid && res_ready) begin
      mq.push_back(res_max);
      iq.push_back(res_id);
      hs_cnt <= hs_cnt + 1;
    end
    if (!watch) c1_early <= 1'b0;
    else if (hs_cnt == watch_base && c1_ready)
      c1_early <= 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic set_beat(input int id, input logic v,
                          input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [2:0] ins,
                          input logic l);
    if (id == 0) begin
      c0_valid = v; c0_a = a; c0_b = b;
      c0_instr = ins; c0_last = l;
    end else begin
      c1_valid = v; c1_a = a; c1_b = b;
      c1_instr = ins; c1_last = l;
    end
  endtask

  // Later beats carry a junk opcode: only beat 0 counts.
  task automatic drive(input int id, input int gap,
                       output int t0);
    int k;
    t0 = 0;
    for (int i = 0; i < jn[id]; i++) begin
      if (i > 0 && gap > 0) begin
        set_beat(id, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
        repeat (gap) @(negedge clk);
      end
      set_beat(id, 1'b1, ja[id][i], jb[id][i],
               (i == 0) ? jins[id] : ~jins[id],
               i == jn[id] - 1);
      if (i == 0) t0 = cyc;
      k = 0;
      while (!(id == 1 ? c1_ready : c0_ready)
             && k < 300) begin
        @(negedge clk);
        k++;
      end
      if (k >= 300) chk("drv_timeout", 32'd1, 32'd0);
      @(negedge clk);
    end
    set_beat(id, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
  endtask

  task automatic get_res(output logic [7:0] m,
                         output logic id,
                         output int rc);
    int k;
    k = 0;
    while (mq.size() == 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (mq.size() == 0) begin
      chk("res_timeout", 32'd1, 32'd0);
      m = 8'hxx; id = 1'bx; rc = -1;
    end else begin
      m = mq.pop_front();
      id = iq.pop_front();
      rc = (rq.size() > 0) ? rq.pop_front() : -1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mq.delete(); iq.delete(); rq.delete();
  endtask

  initial begin
    logic [7:0] m;
    logic       id;
    int         rc, t0, t1, n, g, k;
    logic [7:0] e;

    rst_n = 1'b0;
    res_ready = 1'b1;
    set_beat(0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    set_beat(1, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    #3;
    chk("rst_strobes", {fm_start, fm_valid, fm_one_left,
        c0_ready, c1_ready, res_valid}, 0);
    chk("rst_res", {res_max, res_id}, 0);
    chk("rst_fm", {fm_instruction, fm_data_a,
        fm_data_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-beat add job on client 0.
    jn[0] = 3; jins[0] = 3'd0;
    ja[0][0] = 1;  jb[0][0] = 2;
    ja[0][1] = 10; jb[0][1] = 5;
    ja[0][2] = 3;  jb[0][2] = 3;
    drive(0, 0, t0);
    get_res(m, id, rc);
    chk("t1_max", m, 15);
    chk("t1_id", id, 0);
    chk("t1_lat", rc - t0, 7);
    chk("t1_ol_at", ol_at, 2);
    chk("t1_vcnt", vcnt, 3);

    // Single-beat AND job on client 1.
    jn[1] = 1; jins[1] = 3'd2;
    ja[1][0] = 8'hF0; jb[1][0] = 8'h3C;
    drive(1, 0, t0);
    get_res(m, id, rc);
    chk("t2_max", m, 8'h30);
    chk("t2_id", id, 1);
    chk("t2_lat", rc - t0, 6);
    chk("t2_ol_nov", ol_nov, 1);
    chk("t2_vcnt", vcnt, 1);

    // Both clients request together after reset.
    do_reset();
    jn[0] = 2; jins[0] = 3'd0;
    ja[0][0] = 4; jb[0][0] = 4;
    ja[0][1] = 1; jb[0][1] = 1;
    jn[1] = 2; jins[1] = 3'd0;
    ja[1][0] = 9; jb[1][0] = 9;
    ja[1][1] = 0; jb[1][1] = 1;
    watch_base = hs_cnt;
    watch = 1'b1;
    fork
      drive(0, 0, t0);
      drive(1, 0, t1);
    join
    get_res(m, id, rc);
    chk("t3_first_id", id, 0);
    chk("t3_first_max", m, 8);
    chk("t3_c1_ready_early", c1_early, 0);
    watch = 1'b0;
    get_res(m, id, rc);
    chk("t3_second_id", id, 1);
    chk("t3_second_max", m, 18);

    // Two-cycle bubbles between beats.
    jn[0] = 3; jins[0] = 3'd0;
    ja[0][0] = 7;   jb[0][0] = 0;
    ja[0][1] = 200; jb[0][1] = 50;
    ja[0][2] = 1;   jb[0][2] = 1;
    drive(0, 2, t0);
    get_res(m, id, rc);
    chk("t4_max", m, 250);
    chk("t4_lat", rc - t0, 11);
    chk("t4_vcnt", vcnt, 3);

    // Result stall blocks the pending client 1.
    res_ready = 1'b0;
    jn[0] = 1; jins[0] = 3'd3;
    ja[0][0] = 8'h81; jb[0][0] = 8'h18;
    e = ref_max(0);
    drive(0, 0, t0);
    k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_res_valid_up", res_valid, 1);
    jn[1] = 2; jins[1] = 3'd4;
    ja[1][0] = 8'h55; jb[1][0] = 8'h0F;
    ja[1][1] = 8'h12; jb[1][1] = 8'hFF;
    set_beat(1, 1'b1, ja[1][0], jb[1][0],
             jins[1], 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold", {res_valid, res_max, res_id,
          c1_ready, fm_start}, {1'b1, e, 1'b0,
          1'b0, 1'b0});
    end
    res_ready = 1'b1;
    get_res(m, id, rc);
    chk("t5_max", m, e);
    drive(1, 0, t0);
    get_res(m, id, rc);
    chk("t5_c1_max", m, ref_max(1));
    chk("t5_c1_id", id, 1);

    // Random jobs against the reference model.
    for (int j = 0; j < 8; j++) begin
      id = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 5);
      g = $urandom_range(0, 1);
      jn[id] = n;
      jins[id] = 3'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) begin
        ja[id][i] = 8'($urandom);
        jb[id][i] = 8'($urandom);
      end
      e = ref_max(id);
      k = id;
      drive(k, g, t0);
      get_res(m, id, rc);
      chk("rnd_max", m, e);
      chk("rnd_id", id, k[0]);
      chk("rnd_lat", rc - t0,
          (n == 1) ? 6 : n + 4 + (n - 1) * g);
    end

    // Reset while streaming aborts the job.
    @(negedge clk);
    set_beat(0, 1'b1, 8'h99, 8'h09, 3'd3, 1'b0);
    k = 0;
    while (!fm_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t7_streaming", fm_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_strobes", {fm_start, fm_valid,
        fm_one_left, c0_ready, c1_ready, res_valid}, 0);
    chk("t7_rst_res", {res_max, res_id}, 0);
    chk("t7_rst_fm", {fm_instruction, fm_data_a,
        fm_data_b}, 0);
    set_beat(0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_no_result", mq.size(), 0);
    jn[0] = 1; jins[0] = 3'd0;
    ja[0][0] = 5; jb[0][0] = 6;
    drive(0, 0, t0);
    get_res(m, id, rc);
    chk("t7_clean_max", m, 11);
    chk("t7_clean_id", id, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/find_max_arbiter.md
# find_max_arbiter

Two-client job arbiter and sequencer for the find_MAX datapath. It round-robins whole jobs from two operand-pair streams onto one shared find_MAX instance. For each job it generates find_MAX's start/valid/one_left/instruction protocol, including one-beat look-ahead so one_left is raised in time. It returns the job maximum tagged with the client ID.

## Interface
- DW, 8, operand/result width; fixed at 8 to match find_MAX.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- c0_valid / c1_valid  in  1  client beat valid.
- c0_ready / c1_ready  out  1  client beat accepted when valid&ready.
- c0_a, c0_b / c1_a, c1_b  in  DW  operand pair.
- c0_instr / c1_instr  in  3  Functional_Unit opcode; sampled on the first beat of a job only.
- c0_last / c1_last  in  1  marks the final beat of a job.
- fm_start, fm_valid, fm_one_left  out  1  drive find_MAX start/valid/one_left.
- fm_instruction  out  3  drives find_MAX instruction; held for the whole job.
- fm_data_a, fm_data_b  out  DW  drive find_MAX Data_A/Data_B.
- fm_maximum  in  DW  from find_MAX maximum.
- fm_finish  in  1  from find_MAX finish.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when valid&ready.
- res_max  out  DW  job maximum.
- res_id  out  1  client that owned the job.

## Operation
- States: IDLE, START, FILL, STREAM, ONE_LEFT, LAST, WAIT, RESP.
- **IDLE**
  - If any client is valid, grant it. If both are valid, grant the client other than the last served; the pointer resets to "client 1 last", so client 0 wins first.
  - Register grant id, go to START.
- **START**: fm_start=1 for exactly one cycle, then FILL.
- **FILL**
  - Granted c_ready=1. On accept, load the hold register (a,b) and latch instr into fm_instruction.
  - If c_last, go to ONE_LEFT; otherwise go to STREAM.
  - With no beat offered, stay.
- **STREAM**
  - Granted c_ready=1. On accept: fm_valid=1 with the hold data, and hold is loaded with the new beat.
  - If the new beat has last: fm_one_left=1 in the same cycle, then LAST.
  - With no beat offered: fm_valid=0, stay.
- **ONE_LEFT** (single-beat job only): fm_one_left=1, fm_valid=0, one cycle, then LAST.
- **LAST**: fm_valid=1 with hold data, c_ready=0, then WAIT.
- **WAIT**: when fm_finish=1, capture fm_maximum into res_max and go to RESP. Stay while fm_finish=0.
- **RESP**: res_valid=1. On res_ready, update the RR pointer to res_id and go to IDLE.
- Signal rules:
  - Ungranted client ready is always 0.
  - Granted ready is 0 outside FILL/STREAM.
  - c_ready depends on state only, never on c_valid.
  - fm_valid in STREAM is combinational from granted c_valid.
  - fm_data_a/b always show the hold register.
  - fm_start, fm_one_left and fm_valid are 0 in all states not listed above.
- Max arithmetic is performed by find_MAX: unsigned 8-bit, starting from 0. There is no arithmetic in this block.

## Timing
- Reset values: state=IDLE. All outputs are 0, including res_max, res_id, fm_instruction, hold and ready. RR pointer = 1.
- Reset asserted mid-job aborts the job with no result. The client must restart the job from its first beat.
- Job of N≥2 beats, no bubbles, IDLE grant at cycle 0: START at 1, FILL at 2, STREAM at 3..N+1, LAST at N+2, WAIT at N+3 (fm_finish high), res_valid at N+4.
- Job of N=1: res_valid at cycle 6.
- Each client bubble adds one cycle.
- A res_ready stall holds res_* stable and blocks new grants.
- A request arriving during any non-IDLE state waits. A new grant happens no earlier than the cycle after the RESP handshake.

## Test plan
- Client 0, instr 000, beats (1,2),(10,5),(3,3 last) with no bubbles -> fm_one_left high in the same cycle as the 2nd fm_valid. res_valid at cycle 7, res_max=15, res_id=0.
- Client 1, single beat, instr 010, (0xF0,0x3C,last) -> ONE_LEFT cycle with fm_valid=0, then one fm_valid. res_max=0x30, res_id=1, res_valid at cycle 6.
- Both clients valid right after reset, each with a 2-beat job of instr 000: c0 (4,4),(1,1); c1 (9,9),(0,1) -> first result id=0 max=8, then id=1 max=18. c1_ready stays 0 throughout job 0.
- Client 0 job (7,0),(200,50),(1,1) with 2-cycle gaps in c0_valid -> fm_valid only on accepted beats. res_max=250, with latency increased by exactly 4.
- res_ready held low for 5 cycles -> res_valid/res_max/res_id stable. A pending c1_valid is not granted until after the handshake.
- rst_n pulsed low during STREAM -> all outputs 0 immediately. A subsequent clean job (5,6 last, instr 000) -> res_max=11.
